instr_mem_ctrl: RTL and testbench

//   Word-addressed program/data memory controller upstream of processor.

---
 rtl/instr_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_instr_mem_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ctrl.sv
// Word-addressed program/data memory controller in front of the processor.
// Reads take two cycles after acceptance, writes one. A preload port fills
// the array before a run. Halt is sticky until reset.
module instr_mem_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              sys_dne,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       instruction,
  output logic              ready,
  output logic              err,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic              addr_bad;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [31:0]       mem_wd;

  // Rejected: not word aligned, or beyond the array.
  assign addr_bad = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);

  // Single memory write port shared by preload and committed stores.
  // Reset suppresses both, so a store in flight is dropped.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ld_addr;
    mem_wd = ld_data;
    if (reset) begin
      case (state)
        IDLE:    mem_we = ld_en && !sys_dne;
        HALT:    mem_we = ld_en;
        WR: begin
          mem_we = 1'b1;
          mem_wa = idx;
          mem_wd = wdata_q;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  // Array write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (state == RD1) data_q <= mem[idx];
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      instruction <= INIT_VAL;
      ready       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      idx         <= '0;
      wdata_q     <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (sys_dne) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (ld_en) begin
            state <= IDLE;
          end else if (req) begin
            if (addr_bad) begin
              ready <= 1'b1;
              err   <= 1'b1;
            end else begin
              idx  <= addr[ADDR_W+1:2];
              busy <= 1'b1;
              if (rw) begin
                state <= RD1;
              end else begin
                wdata_q <= wdata;
                state   <= WR;
              end
            end
          end
        end
        RD1: state <= RD2;
        RD2: begin
          instruction <= data_q;
          ready       <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        WR: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: preload, read/write latency, error
// pulses, reset abort, halt behaviour and request-hold handling.
module tb_instr_mem_ctrl;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              rw;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              sys_dne;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic [31:0]       instruction;
  logic              ready;
  logic              err;
  logic              busy;
  logic              halted;

  int total = 0;
  int bad   = 0;
  int rdy_cnt;
  int rdy_dbl;
  logic rdy_prev;

  instr_mem_ctrl #(.ADDR_W(ADDR_W), .INIT_VAL(32'h0)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .sys_dne(sys_dne), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instruction(instruction), .ready(ready), .err(err), .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full read: accept, two internal edges, then check result pulse.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req = 1'b1; rw = 1'b1; addr = a;
    tick();
    req = 1'b0;
    tick();
    tick();
    chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
    chk({tag, "_err"},   {31'b0, err},   32'd0);
    chk({tag, "_data"},  instruction,    exp);
    tick();
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; rw = 1'b1; addr = '0; wdata = '0;
    sys_dne = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #2;
    tick(); tick();
    chk("rst_instr",  instruction,     32'h0);
    chk("rst_ready",  {31'b0, ready},  32'd0);
    chk("rst_err",    {31'b0, err},    32'd0);
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    reset = 1'b1;

    // Preload program words
    ld_en = 1'b1; ld_addr = 8'd0; ld_data = 32'h2AA0ABCD;
    tick();
    ld_addr = 8'd1; ld_data = 32'h458C0280;
    tick();
    ld_en = 1'b0;

    // 1: read latency two edges
    req = 1'b1; rw = 1'b1; addr = 32'h4;
    tick();
    req = 1'b0;
    chk("t1_busy0",  {31'b0, busy},  32'd1);
    chk("t1_rdy0",   {31'b0, ready}, 32'd0);
    tick();
    chk("t1_rdy1",   {31'b0, ready}, 32'd0);
    chk("t1_busy1",  {31'b0, busy},  32'd1);
    tick();
    chk("t1_rdy2",   {31'b0, ready}, 32'd1);
    chk("t1_err",    {31'b0, err},   32'd0);
    chk("t1_data",   instruction,    32'h458C0280);
    chk("t1_busy2",  {31'b0, busy},  32'd0);
    tick();
    chk("t1_pulse",  {31'b0, ready}, 32'd0);

    // 2: store then read back
    req = 1'b1; rw = 1'b0; addr = 32'h10; wdata = 32'hDEB98000;
    tick();
    req = 1'b0;
    chk("t2_busy",  {31'b0, busy},  32'd1);
    chk("t2_rdy0",  {31'b0, ready}, 32'd0);
    tick();
    chk("t2_rdy1",  {31'b0, ready}, 32'd1);
    chk("t2_err",   {31'b0, err},   32'd0);
    chk("t2_idle",  {31'b0, busy},  32'd0);
    tick();
    rd("t2_rb", 32'h10, 32'hDEB98000);

    // 3: misaligned and out-of-range addresses
    req = 1'b1; rw = 1'b1; addr = 32'h6;
    tick();
    req = 1'b0;
    chk("t3a_ready", {31'b0, ready}, 32'd1);
    chk("t3a_err",   {31'b0, err},   32'd1);
    chk("t3a_busy",  {31'b0, busy},  32'd0);
    chk("t3a_data",  instruction,    32'hDEB98000);
    tick();
    chk("t3a_pulse", {30'b0, ready, err}, 32'd0);
    req = 1'b1; rw = 1'b1; addr = 32'h400;
    tick();
    req = 1'b0;
    chk("t3b_ready", {31'b0, ready}, 32'd1);
    chk("t3b_err",   {31'b0, err},   32'd1);
    chk("t3b_data",  instruction,    32'hDEB98000);
    tick();
    chk("t3b_pulse", {30'b0, ready, err}, 32'd0);

    // 4: reset during RD1 aborts the read
    req = 1'b1; rw = 1'b1; addr = 32'h0;
    tick();
    req = 1'b0;
    reset = 1'b0;
    tick();
    chk("t4_ready", {31'b0, ready}, 32'd0);
    chk("t4_instr", instruction,    32'h0);
    chk("t4_busy",  {31'b0, busy},  32'd0);
    reset = 1'b1;
    tick();
    chk("t4_noRdy", {31'b0, ready}, 32'd0);
    chk("t4_instr2", instruction,   32'h0);
    rd("t4_mem0", 32'h0, 32'h2AA0ABCD);

    // 5: halt ignores requests, still accepts preload
    sys_dne = 1'b1;
    tick();
    sys_dne = 1'b0;
    chk("t5_halted", {31'b0, halted}, 32'd1);
    req = 1'b1; rw = 1'b1; addr = 32'h4;
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready || busy) rdy_cnt++;
    end
    req = 1'b0;
    chk("t5_ignored", rdy_cnt, 0);
    ld_en = 1'b1; ld_addr = 8'd2; ld_data = 32'hCAFEF00D;
    tick();
    ld_en = 1'b0;
    chk("t5_still", {31'b0, halted}, 32'd1);
    reset = 1'b0;
    tick();
    chk("t5_unhalt", {31'b0, halted}, 32'd0);
    reset = 1'b1;
    tick();
    rd("t5_hload", 32'h8, 32'hCAFEF00D);

    // 6a: preload wins over a same-cycle request
    ld_en = 1'b1; ld_addr = 8'd3; ld_data = 32'h12345678;
    req = 1'b1; rw = 1'b1; addr = 32'h0;
    tick();
    ld_en = 1'b0; req = 1'b0;
    chk("t6_noacc", {31'b0, busy}, 32'd0);
    tick();
    chk("t6_nordy", {31'b0, ready}, 32'd0);
    rd("t6_load", 32'hC, 32'h12345678);

    // 6b: request held through two reads gives one pulse each
    req = 1'b1; rw = 1'b1; addr = 32'h4;
    rdy_cnt = 0; rdy_dbl = 0; rdy_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready) rdy_cnt++;
      if (ready && rdy_prev) rdy_dbl++;
      rdy_prev = ready;
    end
    req = 1'b0;
    chk("t6_pulses", rdy_cnt, 2);
    chk("t6_dbl",    rdy_dbl, 0);
    chk("t6_data",   instruction, 32'h458C0280);
    tick();
    chk("t6_quiet",  {30'b0, ready, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
